// File: rtl/display_scan_mux.sv
// -----------------------------------------------------------------------------
// display_scan_mux
//   Time-multiplexed scanner for a DIGITS-wide common-anode 7-segment display.
//   A shadow register takes host writes at any time. The live register feeds
//   the display and changes only at the frame boundary, so a frame never mixes
//   old and new digits. Each digit slot starts with a short all-off blanking
//   gap to stop the previous digit ghosting into the next.
//
// Ports
//   clk          in   1          system clock, rising edge
//   rst_n        in   1          asynchronous reset, active low
//   wr_en        in   1          load wr_data into the shadow register
//   wr_data      in   4*DIGITS   digit i = wr_data[4i+3:4i], digit 0 rightmost
//   lzb          in   1          suppress leading zeros (digit 0 always lit)
//   a,b,c,d      out  1 each     current nibble to the decoder, a = bit 3
//   an           out  DIGITS     anode enables, active low, an[i] = digit i
//   frame        out  1          one-cycle pulse at the start of the digit-0 slot
//   upd_pending  out  1          shadow holds a value not yet shown
// -----------------------------------------------------------------------------
module display_scan_mux #(
  parameter int DIGITS    = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [4*DIGITS-1:0]   wr_data,
  input  logic                  lzb,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic [DIGITS-1:0]     an,
  output logic                  frame,
  output logic                  upd_pending
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  // Slot phase; BLANK is skipped entirely when BLANK_CYC is zero.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  logic [CNT_W-1:0]    cnt_reg,    cnt_next;
  logic [IDX_W-1:0]    idx_reg,    idx_next;
  logic [4*DIGITS-1:0] live_reg,   live_next;
  logic [4*DIGITS-1:0] shadow_reg, shadow_next;
  logic                pend_reg,   pend_next;
  logic [3:0]          nib_reg,    nib_next;
  logic [DIGITS-1:0]   an_reg,     an_next;
  logic                frame_reg,  frame_next;
  phase_t              phase_reg,  phase_next;

  logic                wrap;
  logic                boundary;
  logic                suppress;
  logic [3:0]          live_nib [DIGITS];
  logic [DIGITS-1:0]   zero_from;

  // Nibble view of the value that will be live after this edge.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign live_nib[gi] = live_next[4*gi +: 4];
  end

  // zero_from[i] = nibbles i..DIGITS-1 of the next live value are all zero.
  always_comb begin
    logic acc;
    acc       = 1'b1;
    zero_from = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc          = acc & (live_nib[i] == 4'h0);
      zero_from[i] = acc;
    end
  end

  // Next-state logic. Outputs are decoded from the next cnt/idx/live so the
  // registered outputs line up with the state they describe, with no lag.
  always_comb begin
    wrap        = (cnt_reg == CNT_LAST);
    boundary    = wrap && (idx_reg == IDX_LAST);
    cnt_next    = wrap ? '0 : cnt_reg + CNT_W'(1);
    idx_next    = idx_reg;
    live_next   = live_reg;
    shadow_next = shadow_reg;
    pend_next   = pend_reg;
    frame_next  = boundary;

    if (wrap) begin
      idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
    end

    // A write in the boundary cycle goes straight to live and supersedes any
    // older pending value; otherwise the pending shadow is committed.
    if (boundary) begin
      pend_next = 1'b0;
      if (wr_en) begin
        live_next = wr_data;
      end else if (pend_reg) begin
        live_next = shadow_reg;
      end
    end else if (wr_en) begin
      pend_next = 1'b1;
    end
    if (wr_en) begin
      shadow_next = wr_data;
    end

    // Slot phase FSM: BLANK -> SHOW when cnt reaches BLANK_CYC, back to BLANK
    // of the following digit on the wrap.
    phase_next = phase_reg;
    if (BLANK_CYC == 0) begin
      phase_next = PH_SHOW;
    end else begin
      case (phase_reg)
        PH_BLANK: if (cnt_next == BLANK_END) phase_next = PH_SHOW;
        PH_SHOW:  if (wrap)                  phase_next = PH_BLANK;
        default:                             phase_next = PH_BLANK;
      endcase
    end

    // live only changes on a wrap edge, so this nibble is stable per slot.
    nib_next = live_nib[idx_next];

    suppress = lzb && (idx_next != '0) && zero_from[idx_next];
    an_next  = '1;
    if ((phase_next == PH_SHOW) && !suppress) begin
      an_next[idx_next] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg    <= '0;
      idx_reg    <= '0;
      live_reg   <= '0;
      shadow_reg <= '0;
      pend_reg   <= 1'b0;
      nib_reg    <= 4'h0;
      an_reg     <= '1;
      frame_reg  <= 1'b0;
      phase_reg  <= (BLANK_CYC == 0) ? PH_SHOW : PH_BLANK;
    end else begin
      cnt_reg    <= cnt_next;
      idx_reg    <= idx_next;
      live_reg   <= live_next;
      shadow_reg <= shadow_next;
      pend_reg   <= pend_next;
      nib_reg    <= nib_next;
      an_reg     <= an_next;
      frame_reg  <= frame_next;
      phase_reg  <= phase_next;
    end
  end

  assign a           = nib_reg[3];
  assign b           = nib_reg[2];
  assign c           = nib_reg[1];
  assign d           = nib_reg[0];
  assign an          = an_reg;
  assign frame       = frame_reg;
  assign upd_pending = pend_reg;

endmodule
